// File: rtl/img_frame_loader.sv
// rtl/img_frame_loader.sv - byte-stream to IC bit-plane frame assembler for the BNN front end
// Optional build macro: IMG_LOADER_MSB_FIRST_EN (MSB-first pixel order within each byte)
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   s_data/s_valid/s_ready  packed binary pixel byte stream
//   img_in[0:IC-1]          assembled bit-planes, frozen while data_in_ready is high
//   data_in_ready           frame complete, held until the consumer releases it
//   data_out_ready          consumer finished with the frame
//   frame_done              one-cycle pulse when consumer completion is observed
//   byte_count              bytes accepted in the current frame
module img_frame_loader #(
  parameter int IC           = 4,
  parameter int IMG_SIZE     = 30,
  parameter int BYTES_PER_CH = (IMG_SIZE*IMG_SIZE+7)/8,
  parameter int TOTAL_BYTES  = IC*BYTES_PER_CH
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [7:0]                         s_data,
  input  logic                               s_valid,
  output logic                               s_ready,
  output logic [IMG_SIZE*IMG_SIZE-1:0]       img_in [0:IC-1],
  output logic                               data_in_ready,
  input  logic                               data_out_ready,
  output logic                               frame_done,
  output logic [$clog2(TOTAL_BYTES+1)-1:0]   byte_count
);

  localparam int NPIX  = IMG_SIZE*IMG_SIZE;
  localparam int BC_W  = $clog2(TOTAL_BYTES+1);
  localparam int CH_W  = (IC > 1) ? $clog2(IC) : 1;
  localparam int OFF_W = (BYTES_PER_CH > 1) ? $clog2(BYTES_PER_CH) : 1;
  localparam int PIX_W = $clog2(NPIX+8);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    FULL    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              s_ready_q, s_ready_d;
  logic              data_in_ready_q, data_in_ready_d;
  logic              frame_done_q, frame_done_d;
  logic [BC_W-1:0]   byte_count_q, byte_count_d;
  // Channel / in-channel byte offset of the next byte, tracked as counters
  // so no divider is needed on byte_count.
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [NPIX-1:0]   img_q [0:IC-1];
  logic [NPIX-1:0]   img_d [0:IC-1];
  logic [PIX_W-1:0]  pix;
  logic              accept;

  // s_ready_q is only ever high in LOAD, so it doubles as the state qualifier.
  assign accept = s_valid && s_ready_q;

  always_comb begin
    state_d      = state_q;
    byte_count_d = byte_count_q;
    ch_d         = ch_q;
    off_d        = off_q;
    img_d        = img_q;
    frame_done_d = 1'b0;
    pix          = '0;

    case (state_q)
      LOAD: begin
        if (accept) begin
          for (int k = 0; k < 8; k++) begin
            pix = PIX_W'(int'(off_q)*8 + k);
            // Bits past the end of a plane in the channel's last byte are dropped.
            if (pix < PIX_W'(NPIX)) begin
`ifdef IMG_LOADER_MSB_FIRST_EN
              img_d[ch_q][pix] = s_data[7-k];
`else
              img_d[ch_q][pix] = s_data[k];
`endif
            end
          end
          byte_count_d = byte_count_q + 1'b1;
          if (int'(off_q) == BYTES_PER_CH-1) begin
            off_d = '0;
            ch_d  = ch_q + 1'b1;
          end else begin
            off_d = off_q + 1'b1;
          end
          if (int'(byte_count_q) == TOTAL_BYTES-1) begin
            state_d = FULL;
          end
        end
      end
      FULL: begin
        if (data_out_ready) begin
          state_d      = RELEASE;
          frame_done_d = 1'b1;
        end
      end
      RELEASE: begin
        // Wait for the consumer to drop its completion flag before reloading,
        // otherwise a stale high would be taken as completion of the next frame.
        if (!data_out_ready) begin
          state_d      = LOAD;
          byte_count_d = '0;
          ch_d         = '0;
          off_d        = '0;
        end
      end
      default: state_d = LOAD;
    endcase

    // Handshake outputs are registered from the next state so they change on
    // the same edge as the transition that causes them.
    s_ready_d       = (state_d == LOAD);
    data_in_ready_d = (state_d == FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= LOAD;
      s_ready_q       <= 1'b0;
      data_in_ready_q <= 1'b0;
      frame_done_q    <= 1'b0;
      byte_count_q    <= '0;
      ch_q            <= '0;
      off_q           <= '0;
      for (int c = 0; c < IC; c++) begin
        img_q[c] <= '0;
      end
    end else begin
      state_q         <= state_d;
      s_ready_q       <= s_ready_d;
      data_in_ready_q <= data_in_ready_d;
      frame_done_q    <= frame_done_d;
      byte_count_q    <= byte_count_d;
      ch_q            <= ch_d;
      off_q           <= off_d;
      for (int c = 0; c < IC; c++) begin
        img_q[c] <= img_d[c];
      end
    end
  end

  assign s_ready       = s_ready_q;
  assign data_in_ready = data_in_ready_q;
  assign frame_done    = frame_done_q;
  assign byte_count    = byte_count_q;
  assign img_in        = img_q;

endmodule

// File: tb/tb_img_frame_loader.sv
// tb/tb_img_frame_loader.sv - randomized self-checking bench for img_frame_loader
module tb_img_frame_loader;

  localparam int IC    = 4;
  localparam int ISZ   = 30;
  localparam int NPIX  = ISZ*ISZ;
  localparam int BPC   = (NPIX+7)/8;
  localparam int TOTAL = IC*BPC;
  localparam int BC_W  = $clog2(TOTAL+1);

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [7:0]      s_data = 8'h00;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [NPIX-1:0] img_in [0:IC-1];
  logic            data_in_ready;
  logic            data_out_ready = 1'b0;
  logic            frame_done;
  logic [BC_W-1:0] byte_count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] frame [0:TOTAL-1];

  img_frame_loader #(.IC(IC), .IMG_SIZE(ISZ)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .img_in         (img_in),
    .data_in_ready  (data_in_ready),
    .data_out_ready (data_out_ready),
    .frame_done     (frame_done),
    .byte_count     (byte_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference plane: pixel p of channel c comes from byte c*BPC + p/8.
  function automatic logic [NPIX-1:0] exp_plane(input int c);
    logic [NPIX-1:0] v;
    logic [7:0]      b;
    for (int p = 0; p < NPIX; p++) begin
      b = frame[c*BPC + p/8];
`ifdef IMG_LOADER_MSB_FIRST_EN
      v[p] = b[7 - (p % 8)];
`else
      v[p] = b[p % 8];
`endif
    end
    return v;
  endfunction

  task automatic check_planes(input string tag, input bit zero);
    logic [NPIX-1:0] e;
    for (int c = 0; c < IC; c++) begin
      e = zero ? '0 : exp_plane(c);
      check_eq($sformatf("%s_ch%0d_lo", tag, c), 512'(img_in[c][449:0]), 512'(e[449:0]));
      check_eq($sformatf("%s_ch%0d_hi", tag, c), 512'(img_in[c][899:450]), 512'(e[899:450]));
    end
  endtask

  // mode 0: all 0xFF, 1: tail byte of ch0 only, 2: random, 3: byte0=0x01 only
  task automatic fill_frame(input int mode);
    for (int i = 0; i < TOTAL; i++) begin
      case (mode)
        0:       frame[i] = 8'hFF;
        1:       frame[i] = (i == BPC-1) ? 8'hFF : 8'h00;
        3:       frame[i] = (i == 0) ? 8'h01 : 8'h00;
        default: frame[i] = 8'($urandom);
      endcase
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rst_byte_count", 512'(byte_count), 512'(0));
    check_eq("rst_s_ready", 512'(s_ready), 512'(0));
    check_eq("rst_data_in_ready", 512'(data_in_ready), 512'(0));
    check_eq("rst_frame_done", 512'(frame_done), 512'(0));
    check_planes("rst", 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_s_ready", 512'(s_ready), 512'(1));
    check_eq("post_rst_byte_count", 512'(byte_count), 512'(0));
    check_eq("post_rst_data_in_ready", 512'(data_in_ready), 512'(0));
  endtask

  task automatic load_frame(input int n, input int gap_pct);
    int   idx = 0;
    int   cyc = 0;
    logic rdy, vld;
    while (idx < n && cyc < 4000) begin
      @(negedge clk);
      check_eq("byte_count_track", 512'(byte_count), 512'(idx));
      rdy     = s_ready;
      vld     = ($urandom_range(99) >= gap_pct);
      s_valid = vld;
      s_data  = vld ? frame[idx] : 8'($urandom);
      @(posedge clk);
      if (rdy && vld) idx++;
      cyc++;
    end
    if (idx < n) check_eq("load_timeout", 512'(idx), 512'(n));
    @(negedge clk);
    s_valid = 1'b0;
    check_eq("byte_count_end", 512'(byte_count), 512'(n));
    if (n == TOTAL) begin
      check_eq("full_data_in_ready", 512'(data_in_ready), 512'(1));
      check_eq("full_s_ready", 512'(s_ready), 512'(0));
      // An extra byte offered while full must be ignored.
      s_valid = 1'b1;
      s_data  = 8'($urandom);
      @(negedge clk);
      s_valid = 1'b0;
      check_eq("extra_byte_count", 512'(byte_count), 512'(TOTAL));
      check_eq("extra_data_in_ready", 512'(data_in_ready), 512'(1));
    end
  endtask

  task automatic release_frame(input int hold);
    int extra;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      s_data = 8'($urandom);
      s_valid = 1'($urandom);
      check_eq("hold_data_in_ready", 512'(data_in_ready), 512'(1));
      check_eq("hold_frame_done", 512'(frame_done), 512'(0));
    end
    s_valid = 1'b0;
    check_planes("hold", 1'b0);
    data_out_ready = 1'b1;
    @(negedge clk);
    check_eq("rel_frame_done", 512'(frame_done), 512'(1));
    check_eq("rel_data_in_ready", 512'(data_in_ready), 512'(0));
    check_eq("rel_s_ready", 512'(s_ready), 512'(0));
    extra = $urandom_range(2);
    for (int i = 0; i < extra; i++) begin
      @(negedge clk);
      check_eq("rel_wait_frame_done", 512'(frame_done), 512'(0));
      check_eq("rel_wait_s_ready", 512'(s_ready), 512'(0));
    end
    data_out_ready = 1'b0;
    @(negedge clk);
    check_eq("reload_s_ready", 512'(s_ready), 512'(1));
    check_eq("reload_byte_count", 512'(byte_count), 512'(0));
    check_eq("reload_frame_done", 512'(frame_done), 512'(0));
    check_eq("reload_data_in_ready", 512'(data_in_ready), 512'(0));
  endtask

  initial begin
    do_reset();

    fill_frame(0);
    load_frame(TOTAL, 0);
    check_planes("ones", 1'b0);
    release_frame(50);

    fill_frame(1);
    load_frame(TOTAL, 0);
    check_planes("tail", 1'b0);
    check_eq("tail_bits", 512'(img_in[0][899:896]), 512'(4'hF));
    check_eq("no_spill", 512'(img_in[1][7:0]), 512'(8'h00));
    release_frame(3);

    fill_frame(3);
    load_frame(TOTAL, 0);
    check_planes("bitorder", 1'b0);
`ifdef IMG_LOADER_MSB_FIRST_EN
    check_eq("bit_map", 512'(img_in[0][15:0]), 512'(16'h0080));
`else
    check_eq("bit_map", 512'(img_in[0][15:0]), 512'(16'h0001));
`endif
    release_frame(2);

    fill_frame(2);
    load_frame(TOTAL, 30);
    check_planes("gaps", 1'b0);
    release_frame(5);

    fill_frame(2);
    load_frame(200, 20);
    do_reset();
    fill_frame(2);
    load_frame(TOTAL, 10);
    check_planes("after_rst", 1'b0);
    release_frame(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/img_frame_loader.md
# img_frame_loader

Front-end frame assembler for the BNN pipeline: it accepts a byte stream of packed binary pixels and builds the `IC` flat bit-plane images that the first conv/max-pool stage consumes. Once a frame is complete it raises the level-sensitive `data_in_ready` and holds the planes stable until the downstream stage reports completion through its `data_out_ready`. It then releases the stage and accepts the next frame.

## Interface
- `IC`, default 4: number of input channels (bit-planes).
- `IMG_SIZE`, default 30: image side length; each plane holds `IMG_SIZE*IMG_SIZE` bits.
- `BYTES_PER_CH`, default `(IMG_SIZE*IMG_SIZE+7)/8`: bytes per channel (113 at default).
- `TOTAL_BYTES`, default `IC*BYTES_PER_CH`: bytes per frame (452 at default).
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_data`  in  8  packed pixel byte.
- `s_valid`  in  1  `s_data` is valid.
- `s_ready`  out  1  loader accepts a byte this cycle.
- `img_in[0:IC-1]`  out  `IMG_SIZE*IMG_SIZE` each  assembled bit-planes to the conv stage.
- `data_in_ready`  out  1  frame complete; level held until released.
- `data_out_ready`  in  1  downstream stage finished with the frame.
- `frame_done`  out  1  one-cycle pulse when the downstream completion is observed.
- `byte_count`  out  `$clog2(TOTAL_BYTES+1)`  number of bytes accepted in the current frame.

## Operation
- States: LOAD, FULL, RELEASE.
- Reset (async, `rst_n`=0): state LOAD, `byte_count`=0, all `img_in` bits 0, `s_ready`=0 during reset, `data_in_ready`=0, `frame_done`=0.
- LOAD:
  - `s_ready`=1.
  - A byte is accepted on a cycle where `s_valid && s_ready`.
  - Channel `c = byte_count / BYTES_PER_CH`; byte offset `b = byte_count % BYTES_PER_CH`.
  - Bit `k` (0..7) of the byte is written to `img_in[c][b*8+k]`, but only if `b*8+k < IMG_SIZE*IMG_SIZE`. Excess bits in a channel's last byte are discarded.
  - Channels always start on a byte boundary.
  - `byte_count` increments on each accepted byte.
  - When the accepted byte is number `TOTAL_BYTES-1`, the FSM moves to FULL.
- FULL:
  - `s_ready`=0 and `data_in_ready`=1.
  - `img_in` is frozen.
  - On `data_out_ready`=1, move to RELEASE and pulse `frame_done`.
- RELEASE:
  - `data_in_ready`=0 and `s_ready`=0.
  - Wait until `data_out_ready`=0; the consumer clears it one cycle after seeing `data_in_ready` low.
  - Then go to LOAD with `byte_count`=0.
  - Old plane contents persist and are overwritten by the next frame.
- `s_valid` with no ready is ignored. `s_data` may change freely while `s_ready`=0.
- `data_out_ready` is ignored in LOAD.

## Timing
- Acceptance throughput: 1 byte/cycle in LOAD.
- Last byte accepted at edge N: `data_in_ready`=1 and `s_ready`=0 from edge N onward. The byte at N is the last one accepted.
- `data_out_ready` sampled high at edge M:
  - `data_in_ready`=0 and `frame_done`=1 after edge M.
  - `frame_done` returns to 0 after edge M+1.
- `data_out_ready` sampled low in RELEASE at edge R: `s_ready`=1 after edge R.
- Minimum gap between consecutive frames: 2 cycles (FULL→RELEASE→LOAD) when the consumer responds immediately.
- `rst_n` asserted mid-frame or in FULL: all outputs take reset values immediately. Partial frame contents are lost. The downstream stage sees `data_in_ready` fall and must reset itself.
- `data_out_ready` already high on entry to FULL (a stale value): it is treated as completion on the next edge. The consumer must have cleared it while `data_in_ready` was low.

## Configuration
- `IMG_LOADER_MSB_FIRST_EN` defined: bit `7-k` of `s_data` maps to pixel `b*8+k`, i.e. MSB-first per byte.
- Not defined (default): LSB-first mapping as described in Operation.
- Discard of excess bits and all handshakes are identical in both builds.

## Test plan
- Reset checks:
  - Assert `rst_n`=0, release → `s_ready`=1 on the first edge, `byte_count`=0, `data_in_ready`=0.
  - Every `img_in` bit reads 0.
- Full-frame load (defaults):
  - Stream 452 bytes of 0xFF back-to-back → `data_in_ready` rises right after byte 452 and `s_ready`=0.
  - All 900 bits of every plane read 1.
  - A byte 453 presented with `s_valid` is not accepted.
- Tail discard:
  - Channel 0 bytes 0..111 = 0x00, byte 112 = 0xFF, remaining channels 0x00 → `img_in[0][899:896]`=4'hF.
  - `img_in[1]` bits 0..7 read 0, so there is no spill into the next channel.
- Backpressure/valid gaps:
  - Toggle `s_valid` at random over a 452-byte frame → `byte_count` tracks only accepted handshakes.
  - Contents match the golden model.
- Release handshake:
  - Hold `data_out_ready`=0 for 50 cycles → `data_in_ready` stays 1 and `img_in` is stable.
  - Raise `data_out_ready` → one `frame_done` pulse and `data_in_ready` falls.
  - Drop `data_out_ready` → `s_ready`=1 after 1 cycle, `byte_count`=0.
- Reset mid-frame:
  - Assert `rst_n`=0 after 200 bytes → planes clear and `byte_count`=0.
  - A fresh 452-byte frame then loads correctly.
  - With `IMG_LOADER_MSB_FIRST_EN`, byte 0x01 sets only `img_in[0][7]`.
